// File: rtl/dmem_arbiter.sv
// Two-port (core, DMA) arbiter in front of a single-ported data memory.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed core-first priority.
module dmem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // core port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic              c_err,
  output logic [DATA_W-1:0] c_rdata,
  // DMA port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              MemRW,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state  | meaning
  // IDLE   | waiting for a request; arbitrates and latches the winner's payload
  // ACCESS | one memory cycle for the latched transaction
  // RESP   | ack/err/rdata presented to the winning port for one cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;        // 0 = core, 1 = DMA
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_dma;
  logic              out_of_range;
  logic [DATA_W-1:0] resp_data;
  logic              mem_rw;

`ifdef DMEM_ARB_RR_EN
  logic              rr_q, rr_d;          // 1 = DMA favoured on a tie
`endif

  assign out_of_range = |addr_q[31:ADDR_W];

  always_comb begin
`ifdef DMEM_ARB_RR_EN
    pick_dma = d_req && (!c_req || rr_q);
`else
    pick_dma = !c_req;
`endif
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    resp_data = '0;
`ifdef DMEM_ARB_RR_EN
    rr_d      = rr_q;
`endif

    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          gnt_d   = pick_dma;
          we_d    = pick_dma ? d_we    : c_we;
          addr_d  = pick_dma ? d_addr  : c_addr;
          wdata_d = pick_dma ? d_wdata : c_wdata;
          state_d = ACCESS;
`ifdef DMEM_ARB_RR_EN
          rr_d    = ~pick_dma;
`endif
        end
      end
      ACCESS: begin
        // writes and out-of-range accesses return zero read data
        if (!we_q && !out_of_range) begin
          resp_data = mem_rdata;
        end
        if (gnt_q) begin
          d_rdata_d = resp_data;
        end else begin
          c_rdata_d = resp_data;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_rw    = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS && !out_of_range) begin
      mem_addr = addr_q;
      if (we_q) begin
        mem_rw    = 1'b0;
        mem_wdata = wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef DMEM_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign MemRW   = mem_rw;
  assign busy    = (state_q != IDLE);
  assign c_ack   = (state_q == RESP) && !gnt_q;
  assign d_ack   = (state_q == RESP) &&  gnt_q;
  assign c_err   = c_ack && out_of_range;
  assign d_err   = d_ack && out_of_range;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single transactions plus
// hand-written arbitration, mid-transaction reset and idle sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ack, c_err, d_ack, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        MemRW;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  logic [31:0] mem [64];
  int          wr_count = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .MemRW(MemRW), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // behavioural memory: combinational read, write on the rising edge when MemRW=0
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (!MemRW) begin
      mem[mem_addr[5:0]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic        port;      // 0 = core, 1 = DMA
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_wr;    // cycles with MemRW=0 expected
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_wr);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int          lat = 0;
    int          wlow = 0;
    int          bad_err = 0;
    int          other_ack = 0;
    logic        busy_access = 1'b0;
    logic [31:0] other_hold;
    logic [31:0] rd = '0;
    logic        er = 1'b0;
    logic        ack, oack, err_s;
    @(negedge clk);
    other_hold = v.port ? c_rdata : d_rdata;
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
    end
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (!MemRW) wlow++;
      if (n == 1) busy_access = busy;
      ack   = v.port ? d_ack : c_ack;
      oack  = v.port ? c_ack : d_ack;
      err_s = v.port ? d_err : c_err;
      if (oack) other_ack++;
      if (ack) begin
        lat = n;
        rd  = v.port ? d_rdata : c_rdata;
        er  = err_s;
      end else if (err_s) begin
        bad_err++;
      end
    end
    c_req = 1'b0;
    d_req = 1'b0;
    check(lat == 2, $sformatf("v%0d_ack_latency", idx), lat, 2);
    check(rd == v.exp_rdata, $sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    check(er == v.exp_err, $sformatf("v%0d_err", idx), {31'd0, er}, {31'd0, v.exp_err});
    check(wlow == v.exp_wr, $sformatf("v%0d_memrw_low_cycles", idx), wlow, v.exp_wr);
    check(busy_access == 1'b1, $sformatf("v%0d_busy_access", idx), {31'd0, busy_access}, 1);
    check(other_ack == 0 && bad_err == 0, $sformatf("v%0d_stray_ack_err", idx),
          other_ack + bad_err, 0);
    check((v.port ? c_rdata : d_rdata) == other_hold, $sformatf("v%0d_other_rdata_hold", idx),
          v.port ? c_rdata : d_rdata, other_hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          c_acks, c1, c2, d1, lat, stray, wr_snap;
    logic [31:0] crd1, drd;
    int          exp_d1, exp_c2;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    vecs[0]  = mk(1'b0, 1'b1, 32'd17,    32'd56,         32'd0,         1'b0, 1);
    vecs[1]  = mk(1'b0, 1'b0, 32'd17,    32'd0,          32'd56,        1'b0, 0);
    vecs[2]  = mk(1'b0, 1'b1, 32'd15,    32'h15151515,   32'd0,         1'b0, 1);
    vecs[3]  = mk(1'b1, 1'b1, 32'd3,     32'hDEADBEEF,   32'd0,         1'b0, 1);
    vecs[4]  = mk(1'b1, 1'b0, 32'd3,     32'd0,          32'hDEADBEEF,  1'b0, 0);
    vecs[5]  = mk(1'b0, 1'b0, 32'd3,     32'd0,          32'hDEADBEEF,  1'b0, 0);
    vecs[6]  = mk(1'b1, 1'b1, 32'd64,    32'h1234,       32'd0,         1'b1, 0);
    vecs[7]  = mk(1'b1, 1'b0, 32'd0,     32'd0,          32'd0,         1'b0, 0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h100,   32'd0,          32'd0,         1'b1, 0);
    vecs[9]  = mk(1'b0, 1'b1, 32'd63,    32'hA5A5A5A5,   32'd0,         1'b0, 1);
    vecs[10] = mk(1'b0, 1'b0, 32'd63,    32'd0,          32'hA5A5A5A5,  1'b0, 0);
    vecs[11] = mk(1'b0, 1'b1, 32'd17,    32'd7,          32'd0,         1'b0, 1);
    vecs[12] = mk(1'b0, 1'b0, 32'd17,    32'd0,          32'd7,         1'b0, 0);
    vecs[13] = mk(1'b1, 1'b0, 32'd17,    32'd0,          32'd7,         1'b0, 0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(busy == 1'b0 && MemRW == 1'b1, "reset_busy_memrw", {30'd0, busy, MemRW}, 32'd1);
    check({c_ack, c_err, d_ack, d_err} == 4'b0, "reset_ack_err", {28'd0, c_ack, c_err, d_ack, d_err}, 0);
    check(c_rdata == 0 && d_rdata == 0, "reset_rdata", c_rdata | d_rdata, 0);
    check(mem_addr == 0 && mem_wdata == 0, "reset_mem_bus", mem_addr | mem_wdata, 0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_txn(vecs[i], i);

    // simultaneous requests, both held; core re-requests right after its ack
`ifdef DMEM_ARB_RR_EN
    exp_d1 = 5; exp_c2 = 8;
`else
    exp_d1 = 8; exp_c2 = 5;
`endif
    c_acks = 0; c1 = 0; c2 = 0; d1 = 0; crd1 = '0; drd = '0;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd15;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd17;
    for (int n = 1; n <= 15 && !(c_acks == 2 && d1 != 0); n++) begin
      @(negedge clk);
      if (c_ack) begin
        c_acks++;
        if (c_acks == 1) begin c1 = n; crd1 = c_rdata; end
        else begin c2 = n; c_req = 1'b0; end
      end
      if (d_ack) begin d1 = n; drd = d_rdata; d_req = 1'b0; end
    end
    c_req = 1'b0; d_req = 1'b0;
    check(c1 == 2, "arb_core_first_ack", c1, 2);
    check(d1 == exp_d1, "arb_dma_ack_cycle", d1, exp_d1);
    check(c2 == exp_c2, "arb_core_second_ack", c2, exp_c2);
    check(crd1 == 32'h15151515, "arb_core_rdata", crd1, 32'h15151515);
    check(drd == 32'd7, "arb_dma_rdata", drd, 7);

    // reset during ACCESS of a core read, DMA request pending
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd17;
    @(negedge clk);
    check(busy == 1'b1, "rst_mid_busy_access", {31'd0, busy}, 1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd63;
    rst = 1'b1; c_req = 1'b0;
    @(negedge clk);
    check(busy == 1'b0 && c_ack == 1'b0, "rst_mid_idle_no_ack", {30'd0, busy, c_ack}, 0);
    check(c_rdata == 0, "rst_mid_c_rdata", c_rdata, 0);
    rst = 1'b0;
    lat = 0; stray = 0; drd = '0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (c_ack || c_err || d_err) stray++;
      if (d_ack) begin lat = n; drd = d_rdata; end
    end
    d_req = 1'b0;
    check(lat == 2, "rst_mid_dma_latency", lat, 2);
    check(drd == 32'hA5A5A5A5, "rst_mid_dma_rdata", drd, 32'hA5A5A5A5);
    check(stray == 0, "rst_mid_stray_ack_err", stray, 0);

    // idle with no requests
    @(negedge clk);
    wr_snap = wr_count;
    stray = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (MemRW != 1'b1 || busy || c_ack || d_ack || c_err || d_err || mem_addr != 0) stray++;
    end
    check(stray == 0, "idle_outputs", stray, 0);
    check(wr_count == wr_snap, "idle_no_mem_write", wr_count, wr_snap);
    check(mem[0] == 0 && mem[17] == 32'd7 && mem[3] == 32'hDEADBEEF, "final_mem_contents",
          mem[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
